// File: rtl/issue_queue_12_if.sv
// rtl/issue_queue_12_if.sv - dispatch, wakeup and launch-arbiter signal bundle for issue_queue_12
interface issue_queue_12_if #(
  parameter int DW = 160,
  parameter int TW = 6
);
  logic          flush;
  logic [3:0]    disp_valid;
  logic [DW-1:0] disp_data0, disp_data1, disp_data2, disp_data3;
  logic [TW-1:0] disp_s1_tag0, disp_s1_tag1, disp_s1_tag2, disp_s1_tag3;
  logic [TW-1:0] disp_s2_tag0, disp_s2_tag1, disp_s2_tag2, disp_s2_tag3;
  logic          disp_s1_rdy0, disp_s1_rdy1, disp_s1_rdy2, disp_s1_rdy3;
  logic          disp_s2_rdy0, disp_s2_rdy1, disp_s2_rdy2, disp_s2_rdy3;
  logic          disp_ready;
  logic [3:0]    wk_valid;
  logic [TW-1:0] wk_tag0, wk_tag1, wk_tag2, wk_tag3;
  logic [DW-1:0] ready_data0, ready_data1, ready_data2, ready_data3;
  logic [DW-1:0] ready_data4, ready_data5, ready_data6, ready_data7;
  logic [DW-1:0] ready_data8, ready_data9, ready_data10, ready_data11;
  logic [11:0]   lunch_ready;
  logic [11:0]   i_ready;
  logic [3:0]    occ;

  modport master (
    output flush, disp_valid,
    output disp_data0, disp_data1, disp_data2, disp_data3,
    output disp_s1_tag0, disp_s1_tag1, disp_s1_tag2, disp_s1_tag3,
    output disp_s2_tag0, disp_s2_tag1, disp_s2_tag2, disp_s2_tag3,
    output disp_s1_rdy0, disp_s1_rdy1, disp_s1_rdy2, disp_s1_rdy3,
    output disp_s2_rdy0, disp_s2_rdy1, disp_s2_rdy2, disp_s2_rdy3,
    output wk_valid, wk_tag0, wk_tag1, wk_tag2, wk_tag3, i_ready,
    input  disp_ready, lunch_ready, occ,
    input  ready_data0, ready_data1, ready_data2, ready_data3,
    input  ready_data4, ready_data5, ready_data6, ready_data7,
    input  ready_data8, ready_data9, ready_data10, ready_data11
  );

  modport slave (
    input  flush, disp_valid,
    input  disp_data0, disp_data1, disp_data2, disp_data3,
    input  disp_s1_tag0, disp_s1_tag1, disp_s1_tag2, disp_s1_tag3,
    input  disp_s2_tag0, disp_s2_tag1, disp_s2_tag2, disp_s2_tag3,
    input  disp_s1_rdy0, disp_s1_rdy1, disp_s1_rdy2, disp_s1_rdy3,
    input  disp_s2_rdy0, disp_s2_rdy1, disp_s2_rdy2, disp_s2_rdy3,
    input  wk_valid, wk_tag0, wk_tag1, wk_tag2, wk_tag3, i_ready,
    output disp_ready, lunch_ready, occ,
    output ready_data0, ready_data1, ready_data2, ready_data3,
    output ready_data4, ready_data5, ready_data6, ready_data7,
    output ready_data8, ready_data9, ready_data10, ready_data11
  );
endinterface

// File: rtl/issue_queue_12.sv
// rtl/issue_queue_12.sv - 12-slot issue queue with 4-wide dispatch, 4 wakeup buses, reversed grant vector
// Optional macro IQ_SAME_CYCLE_WAKE_EN: presents same-cycle wakeup matches on lunch_ready.
module issue_queue_12 #(
  parameter int DW = 160,
  parameter int TW = 6,
  parameter int NS = 12
) (
  input  logic             clk,
  input  logic             rst,
  issue_queue_12_if.slave  bus
);

  logic [DW-1:0] d_data   [4];
  logic [TW-1:0] d_s1_tag [4];
  logic [TW-1:0] d_s2_tag [4];
  logic [TW-1:0] w_tag    [4];
  logic [3:0]    d_s1_rdy, d_s2_rdy;

  assign d_data[0] = bus.disp_data0;
  assign d_data[1] = bus.disp_data1;
  assign d_data[2] = bus.disp_data2;
  assign d_data[3] = bus.disp_data3;
  assign d_s1_tag[0] = bus.disp_s1_tag0;
  assign d_s1_tag[1] = bus.disp_s1_tag1;
  assign d_s1_tag[2] = bus.disp_s1_tag2;
  assign d_s1_tag[3] = bus.disp_s1_tag3;
  assign d_s2_tag[0] = bus.disp_s2_tag0;
  assign d_s2_tag[1] = bus.disp_s2_tag1;
  assign d_s2_tag[2] = bus.disp_s2_tag2;
  assign d_s2_tag[3] = bus.disp_s2_tag3;
  assign d_s1_rdy = {bus.disp_s1_rdy3, bus.disp_s1_rdy2, bus.disp_s1_rdy1, bus.disp_s1_rdy0};
  assign d_s2_rdy = {bus.disp_s2_rdy3, bus.disp_s2_rdy2, bus.disp_s2_rdy1, bus.disp_s2_rdy0};
  assign w_tag[0] = bus.wk_tag0;
  assign w_tag[1] = bus.wk_tag1;
  assign w_tag[2] = bus.wk_tag2;
  assign w_tag[3] = bus.wk_tag3;

  logic [NS-1:0] valid_q, s1_rdy_q, s2_rdy_q;
  logic [NS-1:0] valid_n, s1_rdy_n, s2_rdy_n;
  logic [TW-1:0] s1_tag_q [NS];
  logic [TW-1:0] s2_tag_q [NS];
  logic [TW-1:0] s1_tag_n [NS];
  logic [TW-1:0] s2_tag_n [NS];
  logic [DW-1:0] pay_q    [NS];
  logic [DW-1:0] pay_n    [NS];
  logic [3:0]    occ_q, occ_n, n_disp, n_grant;

  logic [NS-1:0] s1_wk, s2_wk, lunch, grant, taken;
  logic [3:0]    d_s1_wk, d_s2_wk;
  logic          disp_ready, do_disp, found;

  assign disp_ready = (occ_q <= 4'd8);
  assign do_disp    = disp_ready & ~bus.flush;

  // Tag comparators for resident slots and for incoming dispatch lanes.
  always_comb begin
    s1_wk   = '0;
    s2_wk   = '0;
    d_s1_wk = '0;
    d_s2_wk = '0;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < NS; k++) begin
        if (bus.wk_valid[j] && w_tag[j] == s1_tag_q[k]) s1_wk[k] = 1'b1;
        if (bus.wk_valid[j] && w_tag[j] == s2_tag_q[k]) s2_wk[k] = 1'b1;
      end
      for (int l = 0; l < 4; l++) begin
        if (bus.wk_valid[j] && w_tag[j] == d_s1_tag[l]) d_s1_wk[l] = 1'b1;
        if (bus.wk_valid[j] && w_tag[j] == d_s2_tag[l]) d_s2_wk[l] = 1'b1;
      end
    end
  end

`ifdef IQ_SAME_CYCLE_WAKE_EN
  assign lunch = valid_q & (s1_rdy_q | s1_wk) & (s2_rdy_q | s2_wk);
`else
  assign lunch = valid_q & s1_rdy_q & s2_rdy_q;
`endif

  always_comb begin
    grant = '0;
    for (int k = 0; k < NS; k++) grant[k] = bus.i_ready[NS-1-k] & lunch[k];
  end

  // Slots freed by this cycle's grant are not in the free set until next cycle (taken from valid_q).
  always_comb begin
    valid_n  = valid_q;
    s1_rdy_n = s1_rdy_q | (valid_q & s1_wk);
    s2_rdy_n = s2_rdy_q | (valid_q & s2_wk);
    s1_tag_n = s1_tag_q;
    s2_tag_n = s2_tag_q;
    pay_n    = pay_q;
    taken    = '0;
    found    = 1'b0;
    n_disp   = '0;
    n_grant  = '0;
    for (int k = 0; k < NS; k++) begin
      if (grant[k]) begin
        valid_n[k] = 1'b0;
        n_grant    = n_grant + 4'd1;
      end
    end
    if (do_disp) begin
      for (int l = 0; l < 4; l++) begin
        found = 1'b0;
        if (bus.disp_valid[l]) begin
          for (int k = 0; k < NS; k++) begin
            if (!found && !valid_q[k] && !taken[k]) begin
              found       = 1'b1;
              taken[k]    = 1'b1;
              valid_n[k]  = 1'b1;
              s1_tag_n[k] = d_s1_tag[l];
              s2_tag_n[k] = d_s2_tag[l];
              s1_rdy_n[k] = d_s1_rdy[l] | d_s1_wk[l];
              s2_rdy_n[k] = d_s2_rdy[l] | d_s2_wk[l];
              pay_n[k]    = d_data[l];
              n_disp      = n_disp + 4'd1;
            end
          end
        end
      end
    end
    occ_n = occ_q + n_disp - n_grant;
    if (bus.flush) begin
      valid_n  = '0;
      s1_rdy_n = '0;
      s2_rdy_n = '0;
      occ_n    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      s1_rdy_q <= '0;
      s2_rdy_q <= '0;
      occ_q    <= '0;
    end else begin
      valid_q  <= valid_n;
      s1_rdy_q <= s1_rdy_n;
      s2_rdy_q <= s2_rdy_n;
      occ_q    <= occ_n;
    end
  end

  always_ff @(posedge clk) begin
    s1_tag_q <= s1_tag_n;
    s2_tag_q <= s2_tag_n;
    pay_q    <= pay_n;
  end

  assign bus.disp_ready   = disp_ready;
  assign bus.occ          = occ_q;
  assign bus.lunch_ready  = lunch;
  assign bus.ready_data0  = pay_q[0];
  assign bus.ready_data1  = pay_q[1];
  assign bus.ready_data2  = pay_q[2];
  assign bus.ready_data3  = pay_q[3];
  assign bus.ready_data4  = pay_q[4];
  assign bus.ready_data5  = pay_q[5];
  assign bus.ready_data6  = pay_q[6];
  assign bus.ready_data7  = pay_q[7];
  assign bus.ready_data8  = pay_q[8];
  assign bus.ready_data9  = pay_q[9];
  assign bus.ready_data10 = pay_q[10];
  assign bus.ready_data11 = pay_q[11];

endmodule

// File: tb/tb_issue_queue_12.sv
// tb/tb_issue_queue_12.sv - scoreboard bench for issue_queue_12
module tb_issue_queue_12;
  localparam int DW = 160;
  localparam int TW = 6;
`ifdef IQ_SAME_CYCLE_WAKE_EN
  localparam logic [11:0] SAME_WAKE = 12'h001;
`else
  localparam logic [11:0] SAME_WAKE = 12'h000;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_queue_12_if #(.DW(DW), .TW(TW)) bus();
  issue_queue_12 #(.DW(DW), .TW(TW), .NS(12)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int total = 0;
  int bad   = 0;

  typedef struct { logic [11:0] lr; logic [3:0] occ; logic dr; } st_t;
  typedef struct { int slot; logic [DW-1:0] data; } pay_t;
  st_t  st_q[$];
  pay_t pay_q[$];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] rev12(input logic [11:0] v);
    logic [11:0] r;
    for (int i = 0; i < 12; i++) r[i] = v[11-i];
    return r;
  endfunction

  function automatic logic [DW-1:0] rd(input int k);
    case (k)
      0: return bus.ready_data0;   1: return bus.ready_data1;
      2: return bus.ready_data2;   3: return bus.ready_data3;
      4: return bus.ready_data4;   5: return bus.ready_data5;
      6: return bus.ready_data6;   7: return bus.ready_data7;
      8: return bus.ready_data8;   9: return bus.ready_data9;
      10: return bus.ready_data10; default: return bus.ready_data11;
    endcase
  endfunction

  task automatic clear_in();
    bus.flush = 1'b0; bus.disp_valid = '0; bus.wk_valid = '0; bus.i_ready = '0;
    bus.disp_data0 = '0; bus.disp_data1 = '0; bus.disp_data2 = '0; bus.disp_data3 = '0;
    bus.disp_s1_tag0 = '0; bus.disp_s1_tag1 = '0; bus.disp_s1_tag2 = '0; bus.disp_s1_tag3 = '0;
    bus.disp_s2_tag0 = '0; bus.disp_s2_tag1 = '0; bus.disp_s2_tag2 = '0; bus.disp_s2_tag3 = '0;
    bus.disp_s1_rdy0 = 0; bus.disp_s1_rdy1 = 0; bus.disp_s1_rdy2 = 0; bus.disp_s1_rdy3 = 0;
    bus.disp_s2_rdy0 = 0; bus.disp_s2_rdy1 = 0; bus.disp_s2_rdy2 = 0; bus.disp_s2_rdy3 = 0;
    bus.wk_tag0 = '0; bus.wk_tag1 = '0; bus.wk_tag2 = '0; bus.wk_tag3 = '0;
  endtask

  task automatic lane(input int l, input logic [DW-1:0] d, input logic [TW-1:0] t1, input logic r1,
                      input logic [TW-1:0] t2, input logic r2);
    bus.disp_valid[l] = 1'b1;
    case (l)
      0: begin bus.disp_data0 = d; bus.disp_s1_tag0 = t1; bus.disp_s1_rdy0 = r1; bus.disp_s2_tag0 = t2; bus.disp_s2_rdy0 = r2; end
      1: begin bus.disp_data1 = d; bus.disp_s1_tag1 = t1; bus.disp_s1_rdy1 = r1; bus.disp_s2_tag1 = t2; bus.disp_s2_rdy1 = r2; end
      2: begin bus.disp_data2 = d; bus.disp_s1_tag2 = t1; bus.disp_s1_rdy2 = r1; bus.disp_s2_tag2 = t2; bus.disp_s2_rdy2 = r2; end
      default: begin bus.disp_data3 = d; bus.disp_s1_tag3 = t1; bus.disp_s1_rdy3 = r1; bus.disp_s2_tag3 = t2; bus.disp_s2_rdy3 = r2; end
    endcase
  endtask

  task automatic wake(input int j, input logic [TW-1:0] t);
    bus.wk_valid[j] = 1'b1;
    case (j)
      0: bus.wk_tag0 = t;
      1: bus.wk_tag1 = t;
      2: bus.wk_tag2 = t;
      default: bus.wk_tag3 = t;
    endcase
  endtask

  task automatic rdy_lane(input int l, input int base, input int slot, input bit track);
    pay_t p;
    lane(l, DW'(base + l), '0, 1'b1, '0, 1'b1);
    if (track) begin
      p.slot = slot; p.data = DW'(base + l);
      pay_q.push_back(p);
    end
  endtask

  task automatic cycle(input logic [11:0] lr, input logic [3:0] occ, input logic dr);
    st_t e;
    e.lr = lr; e.occ = occ; e.dr = dr;
    st_q.push_back(e);
    @(posedge clk); #1;
    clear_in();
    e = st_q.pop_front();
    chk("lunch_ready", DW'(bus.lunch_ready), DW'(e.lr));
    chk("occ", DW'(bus.occ), DW'(e.occ));
    chk("disp_ready", DW'(bus.disp_ready), DW'(e.dr));
  endtask

  task automatic check_pay();
    pay_t p;
    while (pay_q.size() > 0) begin
      p = pay_q.pop_front();
      chk($sformatf("pay_rdy%0d", p.slot), DW'(bus.lunch_ready[p.slot]), DW'(1));
      chk($sformatf("pay_data%0d", p.slot), rd(p.slot), p.data);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && (rev12(bus.i_ready) & ~bus.lunch_ready) != 12'h000)
      chk("grant_to_unready", DW'(rev12(bus.i_ready) & ~bus.lunch_ready), '0);
  end

  initial begin
    clear_in();
    rst = 1'b1;
    #12;
    chk("rst_occ", DW'(bus.occ), '0);
    chk("rst_lunch", DW'(bus.lunch_ready), '0);
    chk("rst_disp_ready", DW'(bus.disp_ready), DW'(1));
    @(negedge clk); rst = 1'b0;

    for (int l = 0; l < 4; l++) rdy_lane(l, 'hA0, l, 1);
    cycle(12'h00F, 4'd4, 1'b1);
    check_pay();
    bus.i_ready = 12'hF00;
    cycle(12'h000, 4'd0, 1'b1);

    lane(0, DW'('hB0), 6'd5, 1'b0, 6'd0, 1'b1);
    cycle(12'h000, 4'd1, 1'b1);
    wake(2, 6'd5);
    #1;
    chk("same_cycle_wake", DW'(bus.lunch_ready), DW'(SAME_WAKE));
    pay_q.push_back('{0, DW'('hB0)});
    cycle(12'h001, 4'd1, 1'b1);
    check_pay();
    bus.i_ready = 12'h800;
    cycle(12'h000, 4'd0, 1'b1);
    lane(0, DW'('hB1), 6'd5, 1'b0, 6'd0, 1'b1);
    cycle(12'h000, 4'd1, 1'b1);
    wake(2, 6'd6);
    cycle(12'h000, 4'd1, 1'b1);
    bus.flush = 1'b1;
    cycle(12'h000, 4'd0, 1'b1);

    for (int l = 0; l < 4; l++) rdy_lane(l, 'hD0, l, 0);
    cycle(12'h00F, 4'd4, 1'b1);
    for (int l = 0; l < 4; l++) rdy_lane(l, 'hD4, l + 4, 0);
    cycle(12'h0FF, 4'd8, 1'b1);
    rdy_lane(0, 'hD8, 8, 1);
    cycle(12'h1FF, 4'd9, 1'b0);
    for (int l = 0; l < 4; l++) rdy_lane(l, 'hE0, 0, 0);
    cycle(12'h1FF, 4'd9, 1'b0);
    check_pay();
    bus.i_ready = 12'h008;
    cycle(12'h0FF, 4'd8, 1'b1);

    bus.flush = 1'b1;
    cycle(12'h000, 4'd0, 1'b1);
    for (int l = 0; l < 3; l++) rdy_lane(l, 'h90, l, 0);
    cycle(12'h007, 4'd3, 1'b1);
    bus.i_ready = 12'h400;
    cycle(12'h005, 4'd2, 1'b1);
    rdy_lane(1, 'hC0, 1, 1);
    rdy_lane(3, 'hC0, 3, 1);
    cycle(12'h00F, 4'd4, 1'b1);
    check_pay();

    bus.flush = 1'b1;
    cycle(12'h000, 4'd0, 1'b1);
    lane(0, DW'('hF0), 6'd0, 1'b1, 6'd9, 1'b0);
    wake(0, 6'd9);
    pay_q.push_back('{0, DW'('hF0)});
    cycle(12'h001, 4'd1, 1'b1);
    check_pay();
    bus.i_ready = 12'h800;
    wake(1, 6'd9);
    cycle(12'h000, 4'd0, 1'b1);

    for (int l = 0; l < 2; l++) rdy_lane(l, 'h70, l, 0);
    cycle(12'h003, 4'd2, 1'b1);
    bus.flush = 1'b1;
    for (int l = 0; l < 4; l++) rdy_lane(l, 'h60, l, 0);
    cycle(12'h000, 4'd0, 1'b1);

    for (int l = 0; l < 4; l++) rdy_lane(l, 'h50, l, 0);
    cycle(12'h00F, 4'd4, 1'b1);
    for (int l = 0; l < 3; l++) rdy_lane(l, 'h54, l + 4, 0);
    cycle(12'h07F, 4'd7, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_occ", DW'(bus.occ), '0);
    chk("async_rst_lunch", DW'(bus.lunch_ready), '0);
    chk("async_rst_disp_ready", DW'(bus.disp_ready), DW'(1));
    @(negedge clk); rst = 1'b0;
    cycle(12'h000, 4'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
